multiplexor_seq_mod: RTL and testbench
======================================

# multiplexor_seq_mod

Parametrised, registered N-channel multiplexer with four operating modes: direct select, auto-scan, saturating accumulate and adjacent-channel product. It is the clocked successor of our combinational 4×8-bit multiplexor. It sits between the channel sources and downstream consumers. It delivers one double-width result per accepted sample, with a one-cycle valid strobe.

## Interface
- `W`, default 8: channel width in bits.
- `N`, default 4: number of channels (≥2).
- `SELW`, default 3: SEL/IDX width; must satisfy 2^SELW ≥ N. Codes ≥ N are invalid.
- `CLK`  in  1  system clock; all state updates on rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `DIN`  in  N*W  packed channels; channel i = DIN[i*W +: W].
- `SEL`  in  SELW  channel select (direct/accumulate/product modes).
- `MODE`  in  2  00 direct, 01 scan, 10 accumulate, 11 product.
- `IN_VALID`  in  1  sample strobe; inputs are consumed on cycles where it is high.
- `CLR`  in  1  synchronous clear of R, OVF and the scan pointer.
- `R`  out  2W  registered result, unsigned.
- `en`  out  1  result-valid strobe; high for exactly one cycle per successful sample.
- `IDX`  out  SELW  channel index that produced R (for product mode, the lower index SEL).
- `OVF`  out  1  sticky accumulate-saturation flag.

## Operation
- Reset (RST_N=0, asynchronous): R=0, en=0, IDX=0, OVF=0, scan pointer ptr=0. Reset takes effect immediately, including mid-accumulation.
- The priority order at each edge is RST_N, then CLR, then IN_VALID.
- CLR=1 sets R=0, OVF=0, ptr=0 and en=0, regardless of IN_VALID.
- With IN_VALID=0 and CLR=0: en=0, and R, IDX, OVF and ptr hold.
- Accepted sample (IN_VALID=1, CLR=0), per MODE:
  - Direct: R ← zero-extend(ch[SEL]); IDX ← SEL.
  - Scan: R ← zero-extend(ch[ptr]); IDX ← ptr; ptr ← (ptr+1) mod N, with wrap from N-1 to 0. SEL is ignored.
  - Accumulate: R ← min(R + ch[SEL], 2^(2W)−1); IDX ← SEL. OVF ← 1 if the unsaturated sum exceeds 2^(2W)−1. OVF stays set until CLR or reset.
  - Product: R ← ch[SEL] × ch[(SEL+1) mod N]; IDX ← SEL. The full 2W product always fits.
- Invalid SEL (≥ N) in direct, accumulate or product mode: the sample is rejected. en=0 and R, IDX, OVF hold. Scan mode never rejects.
- ptr only advances in scan mode and holds across mode changes. Returning to scan resumes at the held pointer.
- Accumulate uses the current R as the running sum, so a mode switch into accumulate continues from the last R. Use CLR to start from zero.
- There is no back-pressure. A new sample may be accepted every cycle.

## Timing
- Latency: 1 cycle. An input accepted at edge k shows R/IDX/OVF and en=1 after edge k.
- en is never high for two cycles from one sample. Back-to-back IN_VALID gives continuous en, with R updating each cycle.
- OVF rises in the same cycle as the saturating R.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `multiplexor_pkg`: MODE encodings (MODE_DIRECT, MODE_SCAN, MODE_ACC, MODE_PROD) as localparams.
- One sub-module, `multiplexor_sat_add`: 2W-bit unsigned saturating adder with an overflow output, used by accumulate mode.
- Channel extraction and the mod-N successor index are done inline in the top module.

## Test plan
Use W=8, N=4, SELW=3 with DIN = {192,128,1,170}, i.e. ch0=170, ch1=1, ch2=128, ch3=192.
- Direct: SEL=0,1,2,3, each with one IN_VALID pulse → R=170,1,128,192, each with one-cycle en and IDX matching. Then SEL=4 → en=0, R holds 192.
- Scan: five consecutive IN_VALID cycles → R=170,1,128,192,170 and IDX=0,1,2,3,0, with en continuously high. Switch to direct, then back to scan → resumes at ch1.
- Accumulate: CLR, then SEL=3 repeated 341 times → R=65472, OVF=0. The 342nd sample → R=65535, OVF=1, and further samples keep R=65535.
- Product: SEL=3 → R=32640 (192×170, wrap to ch0). SEL=1 → R=128. With all channels set to 255 and SEL=2 → R=65025.
- Priority: CLR and IN_VALID in the same cycle → R=0, en=0, OVF=0. Assert RST_N low between clock edges mid-accumulate → R, en, IDX and OVF all go to 0 immediately. After release, the first sample produces the expected result one cycle later.

Source files
------------

// File: rtl/multiplexor_seq_mod_pkg.sv
// Shared definitions for the registered N-channel multiplexer.
package multiplexor_pkg;

    // Operating mode encodings carried on MODE.
    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_ACC    = 2'b10;
    localparam logic [1:0] MODE_PROD   = 2'b11;

endpackage

// File: rtl/multiplexor_seq_mod_if.sv
// Sample/result bus between the channel sources, the multiplexer and its consumer.
// Handshake: a sample is taken on every rising CLK edge where IN_VALID=1 and
// CLR=0; there is no ready/back-pressure. en is a one-cycle strobe marking a
// fresh R/IDX, one per accepted sample, asserted the cycle after acceptance.
interface multiplexor_seq_mod_if #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int SELW = 3
) ();
    import multiplexor_pkg::*;

    logic [N*W-1:0]  DIN;
    logic [SELW-1:0] SEL;
    logic [1:0]      MODE;
    logic            IN_VALID;
    logic            CLR;
    logic [2*W-1:0]  R;
    logic            en;
    logic [SELW-1:0] IDX;
    logic            OVF;

    // Source side: drives samples, observes results.
    modport master (
        output DIN, SEL, MODE, IN_VALID, CLR,
        input  R, en, IDX, OVF
    );

    // Multiplexer side.
    modport slave (
        input  DIN, SEL, MODE, IN_VALID, CLR,
        output R, en, IDX, OVF
    );
endinterface

// File: rtl/multiplexor_seq_mod_sat_add.sv
// Unsigned saturating adder: clamps to all-ones and flags when the true sum
// does not fit in WD bits.
module multiplexor_sat_add #(
    parameter int WD = 16
) (
    input  logic [WD-1:0] a_i,
    input  logic [WD-1:0] b_i,
    output logic [WD-1:0] sum_o,
    output logic          ovf_o
);
    logic [WD:0] full_sum;

    // Carry-out of the widened sum is the overflow; saturate on it.
    always_comb begin
        full_sum = {1'b0, a_i} + {1'b0, b_i};
        ovf_o    = full_sum[WD];
        sum_o    = full_sum[WD] ? {WD{1'b1}} : full_sum[WD-1:0];
    end
endmodule

// File: rtl/multiplexor_seq_mod.sv
// Registered N-channel multiplexer: direct select, auto-scan, saturating
// accumulate and adjacent-channel product, one 2W result per accepted sample.
module multiplexor_seq_mod
    import multiplexor_pkg::*;
#(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int SELW = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    multiplexor_seq_mod_if.slave  bus,
    output logic [SELW-1:0]       dbg_ptr_o
);
    logic [W-1:0]    ch [N];
    logic [W-1:0]    ch_sel;
    logic [W-1:0]    ch_nxt;
    logic [W-1:0]    ch_ptr;
    logic [SELW-1:0] nxt_sel;
    logic [SELW-1:0] ptr_inc;
    logic            sel_ok;
    logic [2*W-1:0]  acc_sum;
    logic            acc_ovf;

    logic [2*W-1:0]  r_q, r_d;
    logic            en_q, en_d;
    logic [SELW-1:0] idx_q, idx_d;
    logic            ovf_q, ovf_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    // Channel extraction, mod-N successors and per-index channel lookup.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ch[i] = bus.DIN[i*W +: W];
        end
        sel_ok  = ({1'b0, bus.SEL} < (SELW+1)'(N));
        nxt_sel = (bus.SEL == SELW'(N-1)) ? '0 : bus.SEL + SELW'(1);
        ptr_inc = (ptr_q == SELW'(N-1)) ? '0 : ptr_q + SELW'(1);
        ch_sel  = '0;
        ch_nxt  = '0;
        ch_ptr  = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.SEL == SELW'(i)) ch_sel = ch[i];
            if (nxt_sel == SELW'(i)) ch_nxt = ch[i];
            if (ptr_q   == SELW'(i)) ch_ptr = ch[i];
        end
    end

    // Running sum for accumulate mode continues from the current R.
    multiplexor_sat_add #(.WD(2*W)) u_sat_add (
        .a_i   (r_q),
        .b_i   ((2*W)'(ch_sel)),
        .sum_o (acc_sum),
        .ovf_o (acc_ovf)
    );

    // State register: result, strobe, index, sticky overflow, scan pointer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_q   <= '0;
            en_q  <= 1'b0;
            idx_q <= '0;
            ovf_q <= 1'b0;
            ptr_q <= '0;
        end else begin
            r_q   <= r_d;
            en_q  <= en_d;
            idx_q <= idx_d;
            ovf_q <= ovf_d;
            ptr_q <= ptr_d;
        end
    end

    // Next state: CLR beats IN_VALID; invalid SEL rejects outside scan mode.
    always_comb begin
        r_d   = r_q;
        en_d  = 1'b0;
        idx_d = idx_q;
        ovf_d = ovf_q;
        ptr_d = ptr_q;
        if (bus.CLR) begin
            r_d   = '0;
            ovf_d = 1'b0;
            ptr_d = '0;
        end else if (bus.IN_VALID) begin
            case (bus.MODE)
                MODE_SCAN: begin
                    r_d   = (2*W)'(ch_ptr);
                    idx_d = ptr_q;
                    ptr_d = ptr_inc;
                    en_d  = 1'b1;
                end
                MODE_DIRECT: begin
                    if (sel_ok) begin
                        r_d   = (2*W)'(ch_sel);
                        idx_d = bus.SEL;
                        en_d  = 1'b1;
                    end
                end
                MODE_ACC: begin
                    if (sel_ok) begin
                        r_d   = acc_sum;
                        idx_d = bus.SEL;
                        ovf_d = ovf_q | acc_ovf;
                        en_d  = 1'b1;
                    end
                end
                default: begin
                    if (sel_ok) begin
                        r_d   = (2*W)'(ch_sel) * (2*W)'(ch_nxt);
                        idx_d = bus.SEL;
                        en_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.R     = r_q;
        bus.en    = en_q;
        bus.IDX   = idx_q;
        bus.OVF   = ovf_q;
        dbg_ptr_o = ptr_q;
    end
endmodule

// File: tb/tb_multiplexor_seq_mod.sv
// Directed bench for multiplexor_seq_mod with W=8, N=4, SELW=3.
module tb_multiplexor_seq_mod;
  import multiplexor_pkg::*;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int SELW = 3;

  logic            clk;
  logic            rst_n;
  logic [SELW-1:0] dbg_ptr;

  int err_cnt;
  int chk_cnt;
  logic [2*W-1:0] exp_q[$];

  multiplexor_seq_mod_if #(.W(W), .N(N), .SELW(SELW)) bus_if ();

  multiplexor_seq_mod #(.W(W), .N(N), .SELW(SELW)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .bus       (bus_if.slave),
    .dbg_ptr_o (dbg_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver: present one cycle of inputs, sample #1 after the edge
  task automatic cycle(input logic [1:0] mode, input logic [SELW-1:0] sel,
                       input logic valid, input logic clr);
    bus_if.MODE     = mode;
    bus_if.SEL      = sel;
    bus_if.IN_VALID = valid;
    bus_if.CLR      = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2*W-1:0] r, input logic en,
                           input logic [SELW-1:0] idx, input logic ovf);
    check({tag, ".R"},   32'(bus_if.R),   32'(r));
    check({tag, ".en"},  32'(bus_if.en),  32'(en));
    check({tag, ".IDX"}, 32'(bus_if.IDX), 32'(idx));
    check({tag, ".OVF"}, 32'(bus_if.OVF), 32'(ovf));
  endtask

  logic [2*W-1:0] dir_exp [4];
  logic [2*W-1:0] got;

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    dir_exp[0] = 16'd170; dir_exp[1] = 16'd1; dir_exp[2] = 16'd128; dir_exp[3] = 16'd192;
    rst_n           = 1'b0;
    bus_if.DIN      = {8'd192, 8'd128, 8'd1, 8'd170};
    bus_if.SEL      = '0;
    bus_if.MODE     = MODE_DIRECT;
    bus_if.IN_VALID = 1'b0;
    bus_if.CLR      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 16'd0, 1'b0, 3'd0, 1'b0);
    check("reset.ptr", 32'(dbg_ptr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // direct select
    for (int s = 0; s < 4; s++) begin
      cycle(MODE_DIRECT, SELW'(s), 1'b1, 1'b0);
      check_out($sformatf("direct%0d", s), dir_exp[s], 1'b1, SELW'(s), 1'b0);
    end
    cycle(MODE_DIRECT, 3'd0, 1'b0, 1'b0);
    check_out("idle_hold", 16'd192, 1'b0, 3'd3, 1'b0);
    cycle(MODE_DIRECT, 3'd4, 1'b1, 1'b0);
    check_out("direct_bad_sel", 16'd192, 1'b0, 3'd3, 1'b0);

    // scan: expected results go through the scoreboard queue
    for (int k = 0; k < 5; k++) exp_q.push_back(dir_exp[k % 4]);
    for (int k = 0; k < 5; k++) begin
      cycle(MODE_SCAN, 3'd6, 1'b1, 1'b0);
      got = exp_q.pop_front();
      check_out($sformatf("scan%0d", k), got, 1'b1, SELW'(k % 4), 1'b0);
    end
    check("scan.ptr", 32'(dbg_ptr), 32'd1);
    cycle(MODE_DIRECT, 3'd3, 1'b1, 1'b0);
    check_out("scan_break", 16'd192, 1'b1, 3'd3, 1'b0);
    cycle(MODE_SCAN, 3'd0, 1'b1, 1'b0);
    check_out("scan_resume", 16'd1, 1'b1, 3'd1, 1'b0);

    // accumulate to saturation: 341*192 = 65472, then 65664 clamps
    cycle(MODE_ACC, 3'd3, 1'b0, 1'b1);
    check_out("acc_clr", 16'd0, 1'b0, 3'd1, 1'b0);
    check("acc_clr.ptr", 32'(dbg_ptr), 32'd0);
    for (int k = 0; k < 341; k++) cycle(MODE_ACC, 3'd3, 1'b1, 1'b0);
    check_out("acc341", 16'd65472, 1'b1, 3'd3, 1'b0);
    cycle(MODE_ACC, 3'd3, 1'b1, 1'b0);
    check_out("acc342", 16'd65535, 1'b1, 3'd3, 1'b1);
    cycle(MODE_ACC, 3'd0, 1'b1, 1'b0);
    check_out("acc_sat", 16'd65535, 1'b1, 3'd0, 1'b1);
    cycle(MODE_ACC, 3'd5, 1'b1, 1'b0);
    check_out("acc_bad_sel", 16'd65535, 1'b0, 3'd0, 1'b1);

    // product of adjacent channels (OVF stays sticky)
    cycle(MODE_PROD, 3'd3, 1'b1, 1'b0);
    check_out("prod3", 16'd32640, 1'b1, 3'd3, 1'b1);
    cycle(MODE_PROD, 3'd1, 1'b1, 1'b0);
    check_out("prod1", 16'd128, 1'b1, 3'd1, 1'b1);
    bus_if.DIN = {4{8'd255}};
    cycle(MODE_PROD, 3'd2, 1'b1, 1'b0);
    check_out("prod_max", 16'd65025, 1'b1, 3'd2, 1'b1);
    cycle(MODE_PROD, 3'd7, 1'b1, 1'b0);
    check_out("prod_bad_sel", 16'd65025, 1'b0, 3'd2, 1'b1);

    // CLR beats IN_VALID
    cycle(MODE_ACC, 3'd0, 1'b1, 1'b1);
    check_out("clr_prio", 16'd0, 1'b0, 3'd2, 1'b0);

    // build up OVF again, then async reset between edges
    cycle(MODE_PROD, 3'd1, 1'b1, 1'b0);
    check_out("pre_acc", 16'd65025, 1'b1, 3'd1, 1'b0);
    cycle(MODE_ACC, 3'd1, 1'b1, 1'b0);
    check_out("acc_a", 16'd65280, 1'b1, 3'd1, 1'b0);
    cycle(MODE_ACC, 3'd1, 1'b1, 1'b0);
    check_out("acc_exact", 16'd65535, 1'b1, 3'd1, 1'b0);
    cycle(MODE_ACC, 3'd1, 1'b1, 1'b0);
    check_out("acc_over", 16'd65535, 1'b1, 3'd1, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 16'd0, 1'b0, 3'd0, 1'b0);
    bus_if.IN_VALID = 1'b0;
    bus_if.DIN      = {8'd192, 8'd128, 8'd1, 8'd170};
    #1;
    rst_n = 1'b1;
    cycle(MODE_DIRECT, 3'd2, 1'b1, 1'b0);
    check_out("post_rst", 16'd128, 1'b1, 3'd2, 1'b0);
    cycle(MODE_SCAN, 3'd0, 1'b1, 1'b0);
    check_out("post_rst_scan", 16'd170, 1'b1, 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
